// File: rtl/bip_control.sv
// Multi-cycle control unit of the BIP accumulator processor: fetch, decode and
// datapath strobe generation with PC, run/halt sequencing and a busy-cycle counter.
module bip_control #(
    parameter int len_data   = 16,
    parameter int len_addr   = 11,
    parameter int len_opcode = 5,
    parameter int len_mux_a  = 2,
    parameter int len_count  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [len_data-1:0]  instruction,
    output logic [len_addr-1:0]  pc,
    output logic [len_addr-1:0]  data_addr,
    output logic [len_mux_a-1:0] SelA,
    output logic                 SelB,
    output logic                 WrAcc,
    output logic                 Op,
    output logic                 WrRam,
    output logic                 RdRam,
    output logic                 busy,
    output logic                 halted,
    output logic [len_count-1:0] cycle_count
);

    localparam logic [len_opcode-1:0] OP_HLT  = len_opcode'(0);
    localparam logic [len_opcode-1:0] OP_STO  = len_opcode'(1);
    localparam logic [len_opcode-1:0] OP_LD   = len_opcode'(2);
    localparam logic [len_opcode-1:0] OP_LDI  = len_opcode'(3);
    localparam logic [len_opcode-1:0] OP_ADD  = len_opcode'(4);
    localparam logic [len_opcode-1:0] OP_ADDI = len_opcode'(5);
    localparam logic [len_opcode-1:0] OP_SUB  = len_opcode'(6);
    localparam logic [len_opcode-1:0] OP_SUBI = len_opcode'(7);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;

    state_t                state, state_nx;
    logic [len_data-1:0]   ir;
    logic [len_opcode-1:0] op_in, op_ir;

    assign op_in = instruction[len_data-1 -: len_opcode];
    assign op_ir = ir[len_data-1 -: len_opcode];

    function automatic logic reads_ram(input logic [len_opcode-1:0] o);
        return (o == OP_LD) || (o == OP_ADD) || (o == OP_SUB);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_nx;
            if (state == EXEC) begin
                ir <= instruction;
                pc <= pc + 1'b1;
            end
            if (state == FETCH || state == EXEC || state == WB)
                cycle_count <= cycle_count + 1'b1;
        end
    end

    // Outputs are decoded from state so an asynchronous reset drops every strobe at once.
    always_comb begin
        state_nx  = state;
        data_addr = ir[len_addr-1:0];
        SelA      = '0;
        SelB      = 1'b0;
        WrAcc     = 1'b0;
        Op        = 1'b0;
        WrRam     = 1'b0;
        RdRam     = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                busy      = 1'b1;
                data_addr = instruction[len_addr-1:0];
                WrRam     = (op_in == OP_STO);
                RdRam     = reads_ram(op_in);
                state_nx  = (op_in == OP_HLT) ? HALT : WB;
            end
            WB: begin
                busy     = 1'b1;
                RdRam    = reads_ram(op_ir);
                state_nx = FETCH;
                case (op_ir)
                    OP_LD: WrAcc = 1'b1;
                    OP_LDI: begin
                        SelA  = len_mux_a'(1);
                        WrAcc = 1'b1;
                    end
                    OP_ADD: begin
                        SelA  = len_mux_a'(2);
                        WrAcc = 1'b1;
                    end
                    OP_ADDI: begin
                        SelA  = len_mux_a'(2);
                        SelB  = 1'b1;
                        WrAcc = 1'b1;
                    end
                    OP_SUB: begin
                        SelA  = len_mux_a'(2);
                        Op    = 1'b1;
                        WrAcc = 1'b1;
                    end
                    OP_SUBI: begin
                        SelA  = len_mux_a'(2);
                        SelB  = 1'b1;
                        Op    = 1'b1;
                        WrAcc = 1'b1;
                    end
                    default: ;
                endcase
            end
            HALT: halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: per-instruction expected cycle traces compared every cycle,
// directed programs, reset abort, randomized programs and PC wrap.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] instruction = 16'h0;
    logic [10:0] pc, data_addr;
    logic [1:0]  SelA;
    logic        SelB, WrAcc, Op, WrRam, RdRam, busy, halted;
    logic [15:0] cycle_count;

    logic [15:0] mem [0:2047];
    logic [15:0] prog_q [$];
    logic [35:0] exp_q [$];
    int          exp_da [$];
    int          checks = 0;
    int          failures = 0;

    bip_control dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
        .pc(pc), .data_addr(data_addr), .SelA(SelA), .SelB(SelB),
        .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam),
        .busy(busy), .halted(halted), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data for the presented pc appears one cycle later.
    always @(posedge clk) instruction <= mem[pc];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rec(input logic [10:0] p, input logic [1:0] sa, input logic sb,
                            input logic wa, input logic o, input logic wr, input logic rd,
                            input logic b, input logic h, input logic [15:0] c, input int da);
        exp_q.push_back({p, sa, sb, wa, o, wr, rd, b, h, c});
        exp_da.push_back(da);
    endtask

    // Expected cycle-by-cycle outputs for executing prog_q in order from pc 0.
    task automatic build_trace();
        int          p = 0;
        logic [15:0] c = 16'd0;
        logic [4:0]  op;
        int          a;
        logic        rd;
        push_rec(11'(p), 2'd0, 0, 0, 0, 0, 0, 0, 0, c, -1);
        for (int i = 0; i < prog_q.size(); i++) begin
            op = prog_q[i][15:11];
            a  = int'(prog_q[i][10:0]);
            rd = (op == 5'd2) || (op == 5'd4) || (op == 5'd6);
            push_rec(11'(p), 2'd0, 0, 0, 0, 0, 0, 1, 0, c, -1);
            c = c + 16'd1;
            push_rec(11'(p), 2'd0, 0, 0, 0, op == 5'd1, rd, 1, 0, c, a);
            c = c + 16'd1;
            p = (p + 1) % 2048;
            if (op == 5'd0) begin
                repeat (3) push_rec(11'(p), 2'd0, 0, 0, 0, 0, 0, 0, 1, c, -1);
                break;
            end
            push_rec(11'(p),
                     (op == 5'd3) ? 2'd1 : (op >= 5'd4 && op <= 5'd7) ? 2'd2 : 2'd0,
                     (op == 5'd5) || (op == 5'd7),
                     (op >= 5'd2) && (op <= 5'd7),
                     (op == 5'd6) || (op == 5'd7),
                     0, rd, 1, 0, c, a);
            c = c + 16'd1;
        end
    endtask

    task automatic tick();
        logic [35:0] e;
        int          d;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = exp_da.pop_front();
            chk("trace", 64'({pc, SelA, SelB, WrAcc, Op, WrRam, RdRam, busy, halted, cycle_count}), 64'(e));
            if (d >= 0) chk("data_addr", 64'(data_addr), 64'(d));
        end
        chk("invariant", 64'((WrAcc && WrRam) || (!busy && (WrAcc || WrRam || RdRam))), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_state", 64'({pc, cycle_count, busy, halted, WrAcc, WrRam, RdRam, SelA, SelB, Op}), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog_q.size() && i < 2048; i++) mem[i] = prog_q[i];
    endtask

    task automatic run_prog(input bit patch0, input int budget);
        int n = 0;
        load_prog();
        build_trace();
        start = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            start = ($urandom_range(0, 3) == 0);
            if (patch0 && n == 5) mem[0] = 16'h0000;
            n++;
        end
        start = 1'b0;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL run_timeout remaining=%0d budget=%0d", exp_q.size(), budget);
            exp_q.delete();
            exp_da.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // LDI 5, ADDI 3, STO 0x010, HLT
        prog_q = '{16'h1805, 16'h2803, 16'h0810, 16'h0000};
        run_prog(0, 100);
        chk("t1_pc", 64'(pc), 64'd4);
        chk("t1_cycles", 64'(cycle_count), 64'd11);
        chk("t1_halted", 64'(halted), 64'd1);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("halt_start_ignored", 64'({halted, busy, pc}), 64'({1'b1, 1'b0, 11'd4}));

        // LD 2, SUB 4, HLT
        do_reset();
        prog_q = '{16'h1002, 16'h3004, 16'h0000};
        run_prog(0, 100);
        chk("t2_cycles", 64'(cycle_count), 64'd8);
        chk("t2_pc", 64'(pc), 64'd3);

        // unused opcode then HLT
        do_reset();
        prog_q = '{16'hF800, 16'h0000};
        run_prog(0, 100);
        chk("t3_cycles", 64'(cycle_count), 64'd5);
        chk("t3_pc", 64'(pc), 64'd2);

        // reset during WB of ADD
        do_reset();
        prog_q = '{16'h2005, 16'h0000};
        load_prog();
        build_trace();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        chk("t4_wb_strobe", 64'({WrAcc, SelA, SelB, Op, RdRam}), 64'({1'b1, 2'd2, 1'b0, 1'b0, 1'b1}));
        exp_q.delete();
        exp_da.delete();
        rst_n = 1'b0;
        #1;
        chk("t4_abort", 64'({WrAcc, WrRam, RdRam, busy, halted, pc, cycle_count}), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("t4_idle", 64'({busy, halted, pc, cycle_count}), 64'(0));

        // randomized programs
        repeat (20) begin
            int len;
            logic [4:0] op;
            do_reset();
            prog_q.delete();
            len = $urandom_range(1, 15);
            for (int i = 0; i < len; i++) begin
                op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
                prog_q.push_back({op, 11'($urandom)});
            end
            prog_q.push_back(16'h0000);
            run_prog(0, 100);
            chk("rand_halted", 64'(halted), 64'd1);
        end

        // 2048 NOPs, pc wraps to 0 where HLT has been placed
        do_reset();
        prog_q.delete();
        for (int i = 0; i < 2048; i++) prog_q.push_back({5'($urandom_range(8, 31)), 11'($urandom)});
        prog_q.push_back(16'h0000);
        run_prog(1, 7000);
        chk("wrap_pc", 64'(pc), 64'd1);
        chk("wrap_cycles", 64'(cycle_count), 64'd6146);
        chk("wrap_halted", 64'(halted), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
